// File: rtl/mvd_buf_rd_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvd_buf_rd_ctrl_pkg : shared constants/helpers for the MVD read path | rev 1.0
// ---------------------------------------------------------------------------
package mvd_buf_rd_ctrl_pkg;

  // Slots covering the output FIFO plus the single read in flight.
  localparam int unsigned RD_CREDITS = 2;

  function automatic int unsigned sat_num(input int unsigned num, input int unsigned max_num);
    return ((num == 0) || (num > max_num)) ? max_num : num;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_defines.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enc_defines : shared encoder-wide widths | rev 1.0
// ---------------------------------------------------------------------------
`ifndef ENC_DEFINES_SV
`define ENC_DEFINES_SV
`define MVD_WIDTH 8
`endif
`default_nettype wire

// File: rtl/mvd_buf_rd_ctrl_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvd_rd_fifo2 : 2-entry output FIFO carrying {idx, dat} | rev 1.0
// ---------------------------------------------------------------------------
module mvd_rd_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_i,
  input  logic [W-1:0] wdat_i,
  input  logic         rd_i,
  output logic [W-1:0] rdat_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_wr, do_rd;

  always_comb begin
    do_rd  = rd_i && (cnt_q != 2'd0);
    do_wr  = wr_i && ((cnt_q != 2'd2) || do_rd);
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) begin
      if (wptr_q) mem1_d = wdat_i;
      else        mem0_d = wdat_i;
      wptr_d = ~wptr_q;
    end
    if (do_rd) rptr_d = ~rptr_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0_q <= '0;
      mem1_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Head slot only moves on a pop, so the output holds while stalled.
  assign rdat_o = rptr_q ? mem1_q : mem0_q;
  assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mvd_buf_rd_ctrl.sv
`include "enc_defines.sv"
`default_nettype none
// ---------------------------------------------------------------------------
// mvd_buf_rd_ctrl : fetches one LCU's MVD buffer (rd_2 port) into a 2-deep
// output stream; optional MVD_RD_SKIP_INVALID_EN drops MSB=0 entries | rev 1.0
// ---------------------------------------------------------------------------
module mvd_buf_rd_ctrl
  import mvd_buf_rd_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH = 6,
  parameter int DAT_WIDTH = 2*`MVD_WIDTH+1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [ADR_WIDTH:0]   num_i,
  output logic                 rd_ena_o,
  output logic [ADR_WIDTH-1:0] rd_adr_o,
  input  logic [DAT_WIDTH-1:0] rd_dat_i,
  output logic                 val_o,
  input  logic                 rdy_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic [ADR_WIDTH-1:0] idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned MAX_NUM = 1 << ADR_WIDTH;
  localparam int          FW      = ADR_WIDTH + DAT_WIDTH;

  logic [1:0]           state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [ADR_WIDTH-1:0] last_q, last_d;
  logic [ADR_WIDTH-1:0] fly_adr_q, fly_adr_d;
  logic                 fly_q, fly_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 rd_ena;
  logic [ADR_WIDTH-1:0] rd_adr;
  logic [ADR_WIDTH-1:0] num_last;
  logic                 push, pop;
  logic [1:0]           occ;
  logic [2:0]           pend, occ_next;
  logic                 credit_ok;
  logic [FW-1:0]        fifo_rdat;

  assign num_last = ADR_WIDTH'(sat_num(32'(num_i), MAX_NUM) - 32'd1);

`ifdef MVD_RD_SKIP_INVALID_EN
  assign push = fly_q && rd_dat_i[DAT_WIDTH-1];
`else
  assign push = fly_q;
`endif

  assign val_o = (occ != 2'd0);
  assign pop   = val_o && rdy_i;

  // Credit is judged after this cycle's pop so a steady stream is not throttled.
  assign pend      = {1'b0, occ} + {2'b0, fly_q} - {2'b0, pop};
  assign credit_ok = (pend < 3'(RD_CREDITS));
  assign occ_next  = {1'b0, occ} - {2'b0, pop} + {2'b0, push};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_ena  = 1'b0;
    rd_adr  = '0;
    if (done_q) busy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Address 0 is issued in the start cycle itself.
        if (start_i && rstn) begin
          rd_ena  = 1'b1;
          last_d  = num_last;
          busy_d  = 1'b1;
          adr_d   = (num_last == '0) ? '0 : ADR_WIDTH'(1);
          state_d = (num_last == '0) ? ST_DRAIN : ST_READ;
        end
      end
      ST_READ: begin
        rd_adr = adr_q;
        if (credit_ok) begin
          rd_ena = 1'b1;
          if (adr_q == last_q) state_d = ST_DRAIN;
          else                 adr_d   = adr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (occ_next == 3'd0) begin
          state_d = ST_IDLE;
          adr_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fly_d     = rd_ena;
    fly_adr_d = rd_adr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      last_q    <= '0;
      fly_adr_q <= '0;
      fly_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      last_q    <= last_d;
      fly_adr_q <= fly_adr_d;
      fly_q     <= fly_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  mvd_rd_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .wr_i   (push),
    .wdat_i ({fly_adr_q, rd_dat_i}),
    .rd_i   (pop),
    .rdat_o (fifo_rdat),
    .cnt_o  (occ)
  );

  assign rd_ena_o = rd_ena;
  assign rd_adr_o = rd_adr;
  assign dat_o    = fifo_rdat[DAT_WIDTH-1:0];
  assign idx_o    = fifo_rdat[FW-1:DAT_WIDTH];
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mvd_buf_rd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mvd_buf_rd_ctrl : directed self-checking bench for mvd_buf_rd_ctrl | rev 1.0
// ---------------------------------------------------------------------------
module tb_mvd_buf_rd_ctrl;

  localparam int AW = 6;
  localparam int MW = 8;
  localparam int DW = 2*MW+1;
`ifdef MVD_RD_SKIP_INVALID_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, start_i, rdy_i;
  logic [AW:0]   num_i;
  logic          rd_ena_o, val_o, busy_o, done_o;
  logic [AW-1:0] rd_adr_o, idx_o;
  logic [DW-1:0] rd_dat_i, dat_o;
  logic [DW-1:0] mem [64];

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // Synchronous buffer model: data valid one cycle after the read enable.
  always @(posedge clk) rd_dat_i <= rd_ena_o ? mem[rd_adr_o] : '0;

  mvd_buf_rd_ctrl #(
    .ADR_WIDTH (AW),
    .DAT_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (start_i),
    .num_i    (num_i),
    .rd_ena_o (rd_ena_o),
    .rd_adr_o (rd_adr_o),
    .rd_dat_i (rd_dat_i),
    .val_o    (val_o),
    .rdy_i    (rdy_i),
    .dat_o    (dat_o),
    .idx_o    (idx_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit dropped(input logic [DW-1:0] d);
    return SKIP && !d[DW-1];
  endfunction

  task automatic fill_mem(input int tag, input logic [63:0] msb);
    for (int i = 0; i < 64; i++)
      mem[i] = {msb[i], MW'(i*3 + tag), MW'(i ^ tag)};
  endtask

  task automatic model_exp(input int n);
    exp_q = {};
    for (int i = 0; i < n; i++)
      if (!dropped(mem[i])) exp_q.push_back(i);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_ena"}, rd_ena_o, 0);
    chk({tag, "_rd_adr"}, rd_adr_o, 0);
    chk({tag, "_val"},    val_o,    0);
    chk({tag, "_dat"},    dat_o,    0);
    chk({tag, "_idx"},    idx_o,    0);
    chk({tag, "_busy"},   busy_o,   0);
    chk({tag, "_done"},   done_o,   0);
  endtask

  // One fetch: start in cycle 0, optional extra start, optional early abort.
  task automatic fetch(input int num_in, input int n_reads, input bit stall,
                       input int extra_start, input int abort_at, input int want_done);
    int cyc = 0, issued = 0, xfers = 0, drops = 0, dones = 0, exp_adr = 0;
    int done_at = -1, first_val = -1;
    bit drop_pend = 1'b0, prev_stall = 1'b0, fin = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic [AW-1:0] prev_idx = '0;
    while (!fin) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_val", val_o, 1);
        chk("stall_dat", dat_o, prev_dat);
        chk("stall_idx", idx_o, prev_idx);
      end
      chk("outstanding_le2", 64'((issued - xfers - drops) <= 2), 1);
      if (done_o) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at < 0)         chk("busy_run",   busy_o, 64'(cyc >= 1));
      else if (done_at == cyc) chk("busy_done",  busy_o, 1);
      else                     chk("busy_after", busy_o, 0);
      if (val_o && first_val < 0) first_val = cyc;

      start_i = (cyc == 0) || (cyc == extra_start);
      num_i   = (cyc == extra_start) ? 7'd1 : 7'(num_in);
      rdy_i   = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      drops += int'(drop_pend);
      drop_pend = 1'b0;
      if (rd_ena_o) begin
        chk("rd_adr", rd_adr_o, exp_adr);
        exp_adr++;
        issued++;
        drop_pend = dropped(mem[rd_adr_o]);
      end
      if (val_o && rdy_i) begin
        if (xfers < exp_q.size()) begin
          chk("xfer_idx", idx_o, exp_q[xfers]);
          chk("xfer_dat", dat_o, mem[exp_q[xfers]]);
        end
        xfers++;
      end
      prev_stall = val_o && !rdy_i;
      prev_dat   = dat_o;
      prev_idx   = idx_o;
      if (abort_at > 0 && xfers == abort_at) fin = 1'b1;
      if (done_at >= 0 && cyc >= done_at + 3) fin = 1'b1;
      if (!fin && cyc >= 600) begin
        chk("timeout_done_seen", 64'(done_at >= 0), 1);
        fin = 1'b1;
      end
      cyc++;
    end
    start_i = 1'b0;
    if (abort_at == 0) begin
      chk("xfer_count", xfers, exp_q.size());
      chk("read_count", issued, n_reads);
      chk("done_count", dones, 1);
      if (want_done > 0) begin
        chk("done_cycle", done_at, want_done);
        chk("first_val_cycle", first_val, 2);
      end
    end
  endtask

  initial begin
    rstn    = 1'b0;
    start_i = 1'b0;
    rdy_i   = 1'b0;
    num_i   = '0;
    fill_mem(0, '1);
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rstn = 1'b1;

    // Full 64-entry fetch; a start during the final transfer is ignored.
    fill_mem(1, '1);
    model_exp(64);
    fetch(64, 64, 1'b0, 65, 0, 66);

    // Four entries with rdy 1,0,0 pattern and mixed MSBs.
    fill_mem(2, 64'h5555_5555_5555_5555);
    model_exp(4);
    fetch(4, 4, 1'b1, -1, 0, 0);

    // num=0 saturates to 64; start mid-fetch ignored.
    fill_mem(3, '1);
    model_exp(64);
    fetch(0, 64, 1'b0, 20, 0, 66);

    // num above 64 also saturates.
    fill_mem(4, '1);
    model_exp(64);
    fetch(100, 64, 1'b0, -1, 0, 66);

    // Single entry.
    fill_mem(5, '1);
    model_exp(1);
    fetch(1, 1, 1'b0, -1, 0, 3);

    // Abort after 10 transfers, then restart from address 0.
    fill_mem(6, '1);
    model_exp(64);
    fetch(64, 0, 1'b0, -1, 10, 0);
    rstn = 1'b0;
    #1;
    chk_outputs_zero("abort");
    rdy_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_exp(4);
    fetch(4, 4, 1'b0, -1, 0, 6);

    // MSB pattern 1,0,1,1,0,0,0,1 for entries 0..7.
    fill_mem(7, 64'h0000_0000_0000_008D);
    exp_q = {};
    if (SKIP) exp_q = '{0, 2, 3, 7};
    else for (int i = 0; i < 8; i++) exp_q.push_back(i);
    fetch(8, 8, 1'b0, -1, 0, SKIP ? 0 : 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvd_buf_rd_ctrl.md
MVD_BUF_RD_CTRL -- requirements
Module: mvd_buf_rd_ctrl

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 6: buffer address width (64 entries).
REQ-002 SHALL have parameter DAT_WIDTH, default 2*`MVD_WIDTH+1: entry width; MSB is the entry-valid flag, lower bits are {mvd_y, mvd_x}.
REQ-003 SHALL have port clk, input, 1: clock, rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: one-cycle pulse that begins a fetch of one LCU's MVD buffer.
REQ-006 SHALL have port num_i, input, ADR_WIDTH+1: number of entries to fetch (1..64), sampled on an accepted start_i.
REQ-007 SHALL have port rd_ena_o, output, 1: buffer read enable.
REQ-008 SHALL have port rd_adr_o, output, ADR_WIDTH: buffer read address.
REQ-009 SHALL have port rd_dat_i, input, DAT_WIDTH: buffer read data, valid exactly 1 cycle after rd_ena_o.
REQ-010 SHALL have port val_o, output, 1: output entry valid.
REQ-011 SHALL have port rdy_i, input, 1: downstream ready.
REQ-012 SHALL have port dat_o, output, DAT_WIDTH: output entry.
REQ-013 SHALL have port idx_o, output, ADR_WIDTH: buffer address of the entry on dat_o.
REQ-014 SHALL have port busy_o, output, 1: fetch in progress.
REQ-015 SHALL have port done_o, output, 1: one-cycle pulse when the last entry is transferred.

Function
REQ-016 FSM SHALL have states IDLE, READ, DRAIN; IDLE->READ on start_i; READ->DRAIN when the last read is issued; DRAIN->IDLE when the output FIFO is empty and no read is in flight.
REQ-017 start_i SHALL be ignored outside IDLE.
REQ-018 Reads SHALL issue addresses 0..num_i-1 in ascending order, one per cycle at most.
REQ-019 rd_ena_o SHALL assert only when FIFO occupancy plus reads in flight is less than 2; throughput SHALL be 1 entry/cycle while rdy_i is held high.
REQ-020 Returned data SHALL enter a 2-entry output FIFO; val_o = FIFO not empty; a transfer occurs when val_o and rdy_i are both high.
REQ-021 dat_o/idx_o SHALL hold stable while val_o is high and rdy_i is low.
REQ-022 First val_o SHALL assert 2 cycles after the start_i cycle, provided rdy_i is high.
REQ-023 done_o SHALL pulse in the cycle after the final transfer; busy_o SHALL be high from the cycle after start_i through the done_o cycle.
REQ-024 When num_i is 0 or greater than 64, start_i SHALL be treated as num_i=64 (saturate).
REQ-025 The address counter SHALL NOT wrap; the final address is num_i-1.
REQ-026 If start_i and a final transfer coincide, the start_i SHALL be ignored (the FSM is not in IDLE).

Reset
REQ-027 On rstn low, all state SHALL clear asynchronously: FSM=IDLE, counters=0, FIFO empty; rd_ena_o, val_o, busy_o, done_o=0; rd_adr_o, dat_o, idx_o=0.
REQ-028 Reset during READ or DRAIN SHALL abort the fetch with no done_o, and the FIFO contents SHALL be discarded.

Configuration
REQ-029 With MVD_RD_SKIP_INVALID_EN defined, returned entries with MSB=0 SHALL be dropped (not written into the FIFO, never presented on val_o); done_o SHALL still pulse once all reads have completed and the FIFO is empty, including when every entry is dropped.
REQ-030 Without MVD_RD_SKIP_INVALID_EN, every read entry SHALL be output regardless of MSB.

Structure
REQ-031 MVD_WIDTH SHALL come from the shared enc_defines include; the FSM state encodings SHALL be localparams local to the module.
REQ-032 The 2-entry output FIFO SHALL be one sub-module, mvd_rd_fifo2, carrying {idx, dat}.
REQ-033 The block SHALL connect to the rd_2 port of the 3-buffer rotating MVD memory; rotation is controlled externally, after done_o.

Verification
REQ-034 start_i with num_i=64, rdy_i=1 -> 64 transfers, idx 0..63 in order, first val_o at cycle 2, done_o at cycle 66.
REQ-035 num_i=4, rdy_i toggling 1,0,0,1,... -> no entry lost or duplicated, dat_o stable while stalled, at most 2 reads outstanding.
REQ-036 num_i=0 -> 64 entries output (saturation); start_i pulsed mid-fetch -> ignored, exactly one done_o.
REQ-037 rstn asserted after 10 transfers of a 64-entry fetch -> all outputs 0 immediately; a new start_i then restarts from address 0.
REQ-038 MVD_RD_SKIP_INVALID_EN defined, num_i=8, MSB pattern 10110001 -> exactly 4 entries output, idx 0,2,3,7, followed by one done_o; without the macro -> 8 entries output.
